// File: rtl/adc_spi_master.sv
// adc_spi_master: single-frame SPI master (mode 0) for a serial ADC.
// A frame is 16 SCLK bits: an 8-bit command {1, mux_sel, 0000} MSB first, then 8 bits in
// which the ADC code is read back MSB first on miso.
//
// Ports:
//   clk      - clock, all logic on the rising edge
//   rst      - synchronous active-low reset
//   adc_en   - enable; start is ignored while low
//   start    - conversion request, sampled in idle only
//   mux_sel  - detector channel, legal 3'b001..3'b100
//   result   - last converted ADC code
//   eoc      - one-cycle end-of-conversion pulse; result valid from that cycle on
//   err      - one-cycle pulse when a start is rejected for an illegal mux_sel
//   busy     - high whenever the controller is not idle
//   sclk     - SPI clock, idles low
//   cs_n     - SPI chip select, active-low
//   mosi     - SPI data to the ADC
//   miso     - SPI data from the ADC, synchronous to clk
module adc_spi_master #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       adc_en,
    input  logic       start,
    input  logic [2:0] mux_sel,
    output logic [7:0] result,
    output logic       eoc,
    output logic       err,
    output logic       busy,
    output logic       sclk,
    output logic       cs_n,
    output logic       mosi,
    input  logic       miso
);

    // Wide enough to hold CLK_DIV-1 for every legal CLK_DIV, including 1.
    localparam int unsigned PW = $clog2(CLK_DIV + 1);
    localparam logic [PW-1:0] PhaseLast = PW'(CLK_DIV - 1);

    typedef enum logic [2:0] {StIdle, StCsSetup, StShift, StCsHold, StDone} state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] phase_q, phase_d;
    logic [3:0]    bit_q, bit_d;
    logic          hi_q, hi_d;
    logic [2:0]    sel_q, sel_d;
    logic [7:0]    shreg_q, shreg_d;
    logic [7:0]    result_q, result_d;
    logic          eoc_q, eoc_d;
    logic          err_q, err_d;
    logic          sclk_q, sclk_d;
    logic          cs_n_q, cs_n_d;
    logic          mosi_q, mosi_d;

    logic [7:0] cmd;
    logic       sel_legal;
    logic       phase_end;

    always_comb begin
        cmd       = {1'b1, sel_q, 4'b0000};
        sel_legal = (mux_sel != 3'b000) && (mux_sel <= 3'b100);
        phase_end = (phase_q == PhaseLast);

        state_d  = state_q;
        phase_d  = phase_q;
        bit_d    = bit_q;
        hi_d     = hi_q;
        sel_d    = sel_q;
        shreg_d  = shreg_q;
        result_d = result_q;
        eoc_d    = 1'b0;
        err_d    = 1'b0;
        cs_n_d   = 1'b0;
        sclk_d   = 1'b0;
        mosi_d   = 1'b0;

        // Pin values are computed from the current state and registered, so every
        // SPI pin and pulse is glitch-free and lags the state by one cycle.
        unique case (state_q)
            StIdle: begin
                cs_n_d  = 1'b1;
                phase_d = '0;
                bit_d   = '0;
                hi_d    = 1'b0;
                if (start && adc_en) begin
                    if (sel_legal) begin
                        sel_d   = mux_sel;
                        state_d = StCsSetup;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StCsSetup: begin
                mosi_d = cmd[7];
                if (phase_end) begin
                    phase_d = '0;
                    state_d = StShift;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            StShift: begin
                sclk_d = hi_q;
                // cmd[7-bit] for bits 0..7, zeros afterwards; bit_q only moves at a
                // high->low boundary so mosi changes at the start of a low phase.
                mosi_d = bit_q[3] ? 1'b0 : cmd[~bit_q[2:0]];
                // First cycle of a high phase is the edge that raises sclk.
                if (hi_q && (phase_q == '0) && bit_q[3]) begin
                    shreg_d = {shreg_q[6:0], miso};
                end
                if (phase_end) begin
                    phase_d = '0;
                    hi_d    = ~hi_q;
                    if (hi_q) begin
                        if (bit_q == 4'd15) begin
                            bit_d   = '0;
                            state_d = StCsHold;
                        end else begin
                            bit_d = bit_q + 4'd1;
                        end
                    end
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            StCsHold: begin
                if (phase_end) begin
                    phase_d = '0;
                    state_d = StDone;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            StDone: begin
                cs_n_d   = 1'b1;
                eoc_d    = 1'b1;
                result_d = shreg_q;
                state_d  = StIdle;
            end
            default: begin
                cs_n_d  = 1'b1;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= StIdle;
            phase_q  <= '0;
            bit_q    <= '0;
            hi_q     <= 1'b0;
            sel_q    <= '0;
            shreg_q  <= '0;
            result_q <= '0;
            eoc_q    <= 1'b0;
            err_q    <= 1'b0;
            sclk_q   <= 1'b0;
            cs_n_q   <= 1'b1;
            mosi_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            bit_q    <= bit_d;
            hi_q     <= hi_d;
            sel_q    <= sel_d;
            shreg_q  <= shreg_d;
            result_q <= result_d;
            eoc_q    <= eoc_d;
            err_q    <= err_d;
            sclk_q   <= sclk_d;
            cs_n_q   <= cs_n_d;
            mosi_q   <= mosi_d;
        end
    end

    assign result = result_q;
    assign eoc    = eoc_q;
    assign err    = err_q;
    assign busy   = (state_q != StIdle);
    assign sclk   = sclk_q;
    assign cs_n   = cs_n_q;
    assign mosi   = mosi_q;

endmodule
